// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_emulator
//  Description : Emulates a 4x4 Pmod keypad at the row/column interface.
//                A host requests a press of one hex key for hold_ms ms. The
//                press bounces, holds closed, bounces again and is followed
//                by a forced open-contact gap. Row lines answer the
//                scanner's column strobes with one cycle of latency.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                req_valid/req_ready   - press request handshake
//                req_key, hold_ms      - key code and closed time (0 -> 1 ms)
//                col (in), row (out)   - active-low column strobes / row returns
//                busy, done            - press in progress / end-of-press pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned BOUNCE_CYCLES = 200,
    parameter int unsigned BOUNCE_PERIOD = 16,
    parameter int unsigned GAP_CYCLES    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  req_key,
    input  logic [15:0] hold_ms,
    output logic        req_ready,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        busy,
    output logic        done
);

    localparam int unsigned c_MS_TICKS = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam logic [31:0] c_MS_LAST  = 32'(c_MS_TICKS - 1);
    localparam logic [31:0] c_B_LAST   = 32'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [31:0] c_P_LAST   = 32'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);
    localparam logic [31:0] c_G_LAST   = 32'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic        c_HAS_BOUNCE = (BOUNCE_CYCLES != 0);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_BIN  = 3'd1;
    localparam logic [2:0] c_ST_HOLD = 3'd2;
    localparam logic [2:0] c_ST_BOUT = 3'd3;
    localparam logic [2:0] c_ST_GAP  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [1:0]  r_c, r_r;
    logic [1:0]  w_key_c, w_key_r;
    logic [15:0] r_hold_ms;
    logic [31:0] r_cnt;
    logic [31:0] r_pcnt;
    logic        r_tog;
    logic [31:0] r_ms_pre;
    logic [15:0] r_ms_cnt;
    logic        r_contact;
    logic        w_contact;
    logic [3:0]  r_row;
    logic        r_done;
    logic        w_accept;
    logic        w_leave;
    logic        w_hold_last;

    assign req_ready = (r_state == c_ST_IDLE);
    assign busy      = (r_state != c_ST_IDLE);
    assign row       = r_row;
    assign done      = r_done;
    assign w_accept  = req_valid && req_ready;
    assign w_leave   = (w_state_next != r_state);

    // Last cycle of HOLD: final prescaler tick of the final millisecond.
    assign w_hold_last = (r_ms_pre == c_MS_LAST) && (r_ms_cnt == r_hold_ms - 16'd1);

    // Keypad layout: column c, row r (top to bottom).
    always_comb begin
        w_key_c = 2'd0;
        w_key_r = 2'd0;
        case (req_key)
            4'h1: begin w_key_c = 2'd0; w_key_r = 2'd0; end
            4'h4: begin w_key_c = 2'd0; w_key_r = 2'd1; end
            4'h7: begin w_key_c = 2'd0; w_key_r = 2'd2; end
            4'h0: begin w_key_c = 2'd0; w_key_r = 2'd3; end
            4'h2: begin w_key_c = 2'd1; w_key_r = 2'd0; end
            4'h5: begin w_key_c = 2'd1; w_key_r = 2'd1; end
            4'h8: begin w_key_c = 2'd1; w_key_r = 2'd2; end
            4'hF: begin w_key_c = 2'd1; w_key_r = 2'd3; end
            4'h3: begin w_key_c = 2'd2; w_key_r = 2'd0; end
            4'h6: begin w_key_c = 2'd2; w_key_r = 2'd1; end
            4'h9: begin w_key_c = 2'd2; w_key_r = 2'd2; end
            4'hE: begin w_key_c = 2'd2; w_key_r = 2'd3; end
            4'hA: begin w_key_c = 2'd3; w_key_r = 2'd0; end
            4'hB: begin w_key_c = 2'd3; w_key_r = 2'd1; end
            4'hC: begin w_key_c = 2'd3; w_key_r = 2'd2; end
            default: begin w_key_c = 2'd3; w_key_r = 2'd3; end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_next = c_HAS_BOUNCE ? c_ST_BIN : c_ST_HOLD;
            c_ST_BIN:  if (r_cnt == c_B_LAST) w_state_next = c_ST_HOLD;
            c_ST_HOLD: if (w_hold_last) w_state_next = c_HAS_BOUNCE ? c_ST_BOUT : c_ST_GAP;
            c_ST_BOUT: if (r_cnt == c_B_LAST) w_state_next = c_ST_GAP;
            c_ST_GAP:  if (r_cnt == c_G_LAST) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // r_tog is 0 at the start of each bounce window, so press bounce starts
    // closed and release bounce starts open.
    always_comb begin
        w_contact = 1'b0;
        case (r_state)
            c_ST_BIN:  w_contact = ~r_tog;
            c_ST_HOLD: w_contact = 1'b1;
            c_ST_BOUT: w_contact = r_tog;
            default:   w_contact = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_c       <= 2'd0;
            r_r       <= 2'd0;
            r_hold_ms <= 16'd1;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == c_ST_GAP) && (w_state_next == c_ST_IDLE);
            if (w_accept) begin
                r_c       <= w_key_c;
                r_r       <= w_key_r;
                r_hold_ms <= (hold_ms == 16'd0) ? 16'd1 : hold_ms;
            end
        end
    end

    // Per-state counters, cleared whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst || w_leave) begin
            r_cnt    <= 32'd0;
            r_pcnt   <= 32'd0;
            r_tog    <= 1'b0;
            r_ms_pre <= 32'd0;
            r_ms_cnt <= 16'd0;
        end else begin
            case (r_state)
                c_ST_BIN, c_ST_BOUT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (r_pcnt == c_P_LAST) begin
                        r_pcnt <= 32'd0;
                        r_tog  <= ~r_tog;
                    end else begin
                        r_pcnt <= r_pcnt + 32'd1;
                    end
                end
                c_ST_HOLD: begin
                    if (r_ms_pre == c_MS_LAST) begin
                        r_ms_pre <= 32'd0;
                        r_ms_cnt <= r_ms_cnt + 16'd1;
                    end else begin
                        r_ms_pre <= r_ms_pre + 32'd1;
                    end
                end
                c_ST_GAP: r_cnt <= r_cnt + 32'd1;
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Contact is registered, then the row register gates it with the live
    // column strobe, giving a glitch-free row output one cycle after col.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_contact <= 1'b0;
            r_row     <= 4'b1111;
        end else begin
            r_contact <= w_contact;
            if (r_contact && !col[~r_c])
                r_row <= ~(4'b0001 << ~r_r);
            else
                r_row <= 4'b1111;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_emulator
//  Description : Randomized bench for keypad_emulator. Two instances (no
//                bounce / bounce 32 cycles every 8) share the stimulus; each
//                is compared every cycle against a timeline model that
//                derives contact state from the accept time and the phase
//                lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

    localparam int c_MT = 10;  // CLK_HZ 10_000 -> 10 cycles per ms

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_key;
    logic [15:0] hold_ms;
    logic [3:0]  col;
    logic        ready0, busy0, done0, ready1, busy1, done1;
    logic [3:0]  row0, row1;

    always #5 clk = ~clk;

    keypad_emulator #(
        .CLK_HZ(10_000), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(16), .GAP_CYCLES(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key),
        .hold_ms(hold_ms), .req_ready(ready0), .col(col), .row(row0),
        .busy(busy0), .done(done0)
    );

    keypad_emulator #(
        .CLK_HZ(10_000), .BOUNCE_CYCLES(32), .BOUNCE_PERIOD(8), .GAP_CYCLES(6)
    ) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key),
        .hold_ms(hold_ms), .req_ready(ready1), .col(col), .row(row1),
        .busy(busy1), .done(done1)
    );

    // Model configuration per instance (gap 0 behaves as 1).
    int mB[2] = '{0, 32};
    int mP[2] = '{16, 8};
    int mG[2] = '{1, 6};
    int lay[4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

    // Model state
    bit         act[2];
    int         t0[2], hms[2], kc[2], kr[2];
    bit         creg[2];
    logic [3:0] erow[2];
    bit         edone[2];
    int         cyc = 0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    function automatic int press_len(input int i);
        return 2 * mB[i] + hms[i] * c_MT + mG[i];
    endfunction

    // Whether the contact is closed in cycle k of the current press.
    function automatic bit contact_at(input int i, input int k);
        int d, h;
        if (!act[i]) return 1'b0;
        d = k - t0[i];
        h = hms[i] * c_MT;
        if (d < 0) return 1'b0;
        if (d < mB[i]) return ((d / mP[i]) % 2) == 0;
        if (d < mB[i] + h) return 1'b1;
        if (d < 2 * mB[i] + h) return ((d - mB[i] - h) / mP[i]) % 2 == 1;
        return 1'b0;
    endfunction

    task automatic step();
        logic        rv, rs;
        logic [3:0]  rk, cl, m;
        logic [15:0] hm;
        bit          was;
        rv = req_valid; rs = rst; rk = req_key; cl = col; hm = hold_ms;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                act[i] = 1'b0; creg[i] = 1'b0; erow[i] = 4'hF; edone[i] = 1'b0;
            end else begin
                m = 4'hF;
                if (creg[i] && !cl[3 - kc[i]]) m[3 - kr[i]] = 1'b0;
                erow[i]  = m;
                creg[i]  = contact_at(i, cyc - 1);
                edone[i] = 1'b0;
                was      = act[i];
                if (act[i] && (cyc - t0[i]) == press_len(i)) begin
                    edone[i] = 1'b1;
                    act[i]   = 1'b0;
                end
                if (!was && rv) begin
                    act[i] = 1'b1;
                    t0[i]  = cyc;
                    hms[i] = (hm == 16'd0) ? 1 : int'(hm);
                    for (int c = 0; c < 4; c++)
                        for (int r = 0; r < 4; r++)
                            if (lay[c][r] == int'(rk)) begin kc[i] = c; kr[i] = r; end
                end
            end
        end
        #1;
        check("row0",   row0,             erow[0]);
        check("busy0",  {3'b000, busy0},  {3'b000, act[0]});
        check("ready0", {3'b000, ready0}, {3'b000, !act[0]});
        check("done0",  {3'b000, done0},  {3'b000, edone[0]});
        check("row1",   row1,             erow[1]);
        check("busy1",  {3'b000, busy1},  {3'b000, act[1]});
        check("ready1", {3'b000, ready1}, {3'b000, !act[1]});
        check("done1",  {3'b000, done1},  {3'b000, edone[1]});
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; creg[i] = 1'b0; erow[i] = 4'hF; edone[i] = 1'b0;
            t0[i] = 0; hms[i] = 1; kc[i] = 0; kr[i] = 0;
        end
        rst = 1'b1; req_valid = 1'b0; req_key = 4'h0; hold_ms = 16'd0; col = 4'b0000;
        for (int n = 0; n < 3; n++) step();
        rst = 1'b0;
        for (int n = 0; n < 8000; n++) begin
            step();
            rst       = ($urandom_range(0, 499) == 0);
            req_valid = ($urandom_range(0, 3) == 0);
            req_key   = 4'($urandom_range(0, 15));
            hold_ms   = 16'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    col = ~(4'b0001 << $urandom_range(0, 3));
                2:       col = 4'($urandom_range(0, 15));
                default: col = 4'b0000;
            endcase
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
